// File: rtl/square_select_pkg.sv
// Shared constants for the tic-tac-toe square selector: grid bounds, FSM encoding, players.
package square_select_pkg;

    localparam int GRID_N  = 9;
    localparam int COORD_W = 12;
    localparam int IDX_W   = 4;

    // Inclusive pixel bounds of the three columns and three rows
    localparam logic [COORD_W-1:0] COL0_LO = 12'd8;
    localparam logic [COORD_W-1:0] COL0_HI = 12'd343;
    localparam logic [COORD_W-1:0] COL1_LO = 12'd344;
    localparam logic [COORD_W-1:0] COL1_HI = 12'd679;
    localparam logic [COORD_W-1:0] COL2_LO = 12'd680;
    localparam logic [COORD_W-1:0] COL2_HI = 12'd1015;

    localparam logic [COORD_W-1:0] ROW0_LO = 12'd10;
    localparam logic [COORD_W-1:0] ROW0_HI = 12'd258;
    localparam logic [COORD_W-1:0] ROW1_LO = 12'd259;
    localparam logic [COORD_W-1:0] ROW1_HI = 12'd507;
    localparam logic [COORD_W-1:0] ROW2_LO = 12'd508;
    localparam logic [COORD_W-1:0] ROW2_HI = 12'd756;

    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_COMMIT,
        ST_WAIT_RELEASE
    } state_t;

    function automatic logic [GRID_N-1:0] square_bit(input logic [IDX_W-1:0] idx);
        logic [GRID_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/square_select_if.sv
// Board-side bundle of the square selector. With SQUARE_SELECT_HOVER_EN a hover one-hot is added.
interface square_select_if;
    import square_select_pkg::*;

    logic [COORD_W-1:0] xpos;
    logic [COORD_W-1:0] ypos;
    logic               mouse_left;
    logic               start_en;
    logic [GRID_N-1:0]  square;
    logic [GRID_N-1:0]  owner;
    logic               turn;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               grid_full;
`ifdef SQUARE_SELECT_HOVER_EN
    logic [GRID_N-1:0]  hover;

    modport master (
        output xpos, ypos, mouse_left, start_en,
        input  square, owner, turn, sel_valid, sel_idx, grid_full, hover
    );
    modport slave (
        input  xpos, ypos, mouse_left, start_en,
        output square, owner, turn, sel_valid, sel_idx, grid_full, hover
    );
`else
    modport master (
        output xpos, ypos, mouse_left, start_en,
        input  square, owner, turn, sel_valid, sel_idx, grid_full
    );
    modport slave (
        input  xpos, ypos, mouse_left, start_en,
        output square, owner, turn, sel_valid, sel_idx, grid_full
    );
`endif

endinterface

// File: rtl/square_select_grid_decode.sv
// Combinational pixel -> board square decode; index = row*3 + col, 0 when off the board.
module grid_decode
    import square_select_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               in_grid,
    output logic [IDX_W-1:0]   index
);

    logic [1:0] col;
    logic [1:0] row;
    logic       col_ok;
    logic       row_ok;

    always_comb begin
        col    = 2'd0;
        col_ok = 1'b1;
        if (x >= COL0_LO && x <= COL0_HI)      col = 2'd0;
        else if (x >= COL1_LO && x <= COL1_HI) col = 2'd1;
        else if (x >= COL2_LO && x <= COL2_HI) col = 2'd2;
        else                                   col_ok = 1'b0;

        row    = 2'd0;
        row_ok = 1'b1;
        if (y >= ROW0_LO && y <= ROW0_HI)      row = 2'd0;
        else if (y >= ROW1_LO && y <= ROW1_HI) row = 2'd1;
        else if (y >= ROW2_LO && y <= ROW2_HI) row = 2'd2;
        else                                   row_ok = 1'b0;

        in_grid = col_ok & row_ok;
        index   = in_grid ? ({2'b00, row} * 4'd3 + {2'b00, col}) : 4'd0;
    end

endmodule

// File: rtl/square_select.sv
// Mouse-click square selector for a 3x3 board. Define SQUARE_SELECT_HOVER_EN for the hover output.
module square_select
    import square_select_pkg::*;
(
    input  logic          pclk,
    input  logic          rst,
    square_select_if.slave bus
);

    state_t state, state_nxt;

    logic               sync1, sync2, sync_d;
    logic [1:0]         sync_fill;
    logic               armed;
    logic               press;

    logic [COORD_W-1:0] lat_x, lat_y;
    logic               dec_in_grid;
    logic [IDX_W-1:0]   dec_index;
    logic               in_grid_q;
    logic [IDX_W-1:0]   index_q;

    logic [GRID_N-1:0]  square, owner;
    logic               turn, sel_valid, grid_full;
    logic [IDX_W-1:0]   sel_idx;

    logic               latch_en, decode_en, commit_try, commit_ok;

    // The synchronizer resets to 0, so a button held through reset would look like
    // a fresh edge; only arm once a valid low level has been seen after the chain fills.
    assign press = sync2 & ~sync_d & armed;

    always_ff @(posedge pclk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        latch_en   = 1'b0;
        decode_en  = 1'b0;
        commit_try = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press && bus.start_en) begin
                    latch_en  = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                decode_en = 1'b1;
                state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit_try = 1'b1;
                state_nxt  = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (!sync2) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!bus.start_en) state_nxt = ST_IDLE;
    end

    assign commit_ok = commit_try & in_grid_q & ~square[index_q] & ~grid_full;

    grid_decode u_decode (
        .x       (lat_x),
        .y       (lat_y),
        .in_grid (dec_in_grid),
        .index   (dec_index)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_d    <= 1'b0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
            lat_x     <= '0;
            lat_y     <= '0;
            in_grid_q <= 1'b0;
            index_q   <= '0;
            square    <= '0;
            owner     <= '0;
            turn      <= PLAYER_X;
            sel_valid <= 1'b0;
            sel_idx   <= '0;
            grid_full <= 1'b0;
        end else begin
            sync1     <= bus.mouse_left;
            sync2     <= sync1;
            sync_d    <= sync2;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (~sync2 & sync_fill[1]);
            sel_valid <= 1'b0;
            grid_full <= &square;

            if (latch_en) begin
                lat_x <= bus.xpos;
                lat_y <= bus.ypos;
            end
            if (decode_en) begin
                in_grid_q <= dec_in_grid;
                index_q   <= dec_index;
            end

            // Leaving the game wins over a commit landing on the same edge
            if (!bus.start_en) begin
                square  <= '0;
                owner   <= '0;
                turn    <= PLAYER_X;
                sel_idx <= '0;
            end else if (commit_ok) begin
                square         <= square | square_bit(index_q);
                owner[index_q] <= turn;
                turn           <= (turn == PLAYER_X) ? PLAYER_O : PLAYER_X;
                sel_idx        <= index_q + 4'd1;
                sel_valid      <= 1'b1;
            end
        end
    end

    assign bus.square    = square;
    assign bus.owner     = owner;
    assign bus.turn      = turn;
    assign bus.sel_valid = sel_valid;
    assign bus.sel_idx   = sel_idx;
    assign bus.grid_full = grid_full;

`ifdef SQUARE_SELECT_HOVER_EN
    logic              hov_in_grid;
    logic [IDX_W-1:0]  hov_index;
    logic [GRID_N-1:0] hover;

    grid_decode u_hover (
        .x       (bus.xpos),
        .y       (bus.ypos),
        .in_grid (hov_in_grid),
        .index   (hov_index)
    );

    always_ff @(posedge pclk) begin
        if (rst)                            hover <= '0;
        else if (bus.start_en && hov_in_grid) hover <= square_bit(hov_index);
        else                                hover <= '0;
    end

    assign bus.hover = hover;
`endif

endmodule

// File: tb/tb_square_select.sv
// Directed bench for square_select: latency, occupancy, bounds, hold, fill, clear and reset abort.
module tb_square_select;

    logic pclk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 pclk = ~pclk;

    square_select_if bus ();

    square_select dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic click(input logic [11:0] x, input logic [11:0] y, input int hold,
                         output int pulses, output logic [3:0] idx);
        bus.xpos = x;
        bus.ypos = y;
        bus.mouse_left = 1'b1;
        pulses = 0;
        idx = 4'd0;
        repeat (hold) begin
            tick();
            if (bus.sel_valid) begin pulses++; idx = bus.sel_idx; end
        end
        bus.mouse_left = 1'b0;
        repeat (8) begin
            tick();
            if (bus.sel_valid) begin pulses++; idx = bus.sel_idx; end
        end
    endtask

    task automatic clear_board();
        bus.start_en = 1'b0;
        tick();
        bus.start_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mouse_left = 1'b0;
        bus.start_en = 1'b1;
        bus.xpos = 12'd0;
        bus.ypos = 12'd0;
        repeat (3) tick();
        vectors++;
        if (bus.square !== 9'h000 || bus.owner !== 9'h000 || bus.turn !== 1'b0 ||
            bus.sel_valid !== 1'b0 || bus.sel_idx !== 4'd0 || bus.grid_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got sq=%h own=%h turn=%b v=%b idx=%0d full=%b want all zero",
                     bus.square, bus.owner, bus.turn, bus.sel_valid, bus.sel_idx, bus.grid_full);
        end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_center_latency();
        bit early = 0;
        bus.xpos = 12'd500;
        bus.ypos = 12'd300;
        bus.mouse_left = 1'b1;
        repeat (4) begin
            tick();
            if (bus.sel_valid !== 1'b0 || bus.square !== 9'h000) early = 1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL center_early: output changed before 5th edge, want no change");
        end
        tick();
        vectors++;
        if (bus.sel_valid !== 1'b1 || bus.square !== 9'h010 || bus.owner[4] !== 1'b0 ||
            bus.sel_idx !== 4'd5 || bus.turn !== 1'b1) begin
            miscompares++;
            $display("FAIL center_commit: got v=%b sq=%h own4=%b idx=%0d turn=%b want v=1 sq=010 own4=0 idx=5 turn=1",
                     bus.sel_valid, bus.square, bus.owner[4], bus.sel_idx, bus.turn);
        end
        tick();
        vectors++;
        if (bus.sel_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL center_pulse_width: got v=%b want 0", bus.sel_valid);
        end
        bus.mouse_left = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_repeat_click();
        int p; logic [3:0] ix;
        click(12'd500, 12'd300, 8, p, ix);
        vectors++;
        if (p !== 0 || bus.square !== 9'h010 || bus.turn !== 1'b1) begin
            miscompares++;
            $display("FAIL repeat_click: got pulses=%0d sq=%h turn=%b want 0 010 1", p, bus.square, bus.turn);
        end
    endtask

    task automatic test_outside();
        logic [11:0] xs [6] = '{12'd0, 12'd1016, 12'd7,   12'd175, 12'd1016, 12'd175};
        logic [11:0] ys [6] = '{12'd0, 12'd757,  12'd134, 12'd9,   12'd134,  12'd757};
        int p; logic [3:0] ix;
        for (int i = 0; i < 6; i++) begin
            click(xs[i], ys[i], 8, p, ix);
            vectors++;
            if (p !== 0 || bus.square !== 9'h010 || bus.turn !== 1'b1) begin
                miscompares++;
                $display("FAIL outside_%0d: (%0d,%0d) got pulses=%0d sq=%h turn=%b want 0 010 1",
                         i, xs[i], ys[i], p, bus.square, bus.turn);
            end
        end
    endtask

    task automatic test_hold();
        int p; logic [3:0] ix;
        click(12'd100, 12'd100, 1000, p, ix);
        vectors++;
        if (p !== 1 || ix !== 4'd1 || bus.square !== 9'h011 || bus.owner !== 9'h001 || bus.turn !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_single: got pulses=%0d idx=%0d sq=%h own=%h turn=%b want 1 1 011 001 0",
                     p, ix, bus.square, bus.owner, bus.turn);
        end
    endtask

    task automatic test_clear();
        bus.start_en = 1'b0;
        tick();
        bus.start_en = 1'b1;
        vectors++;
        if (bus.square !== 9'h000 || bus.owner !== 9'h000 || bus.turn !== 1'b0 ||
            bus.sel_idx !== 4'd0 || bus.sel_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_outputs: got sq=%h own=%h turn=%b idx=%0d v=%b want all zero",
                     bus.square, bus.owner, bus.turn, bus.sel_idx, bus.sel_valid);
        end
        tick();
        vectors++;
        if (bus.grid_full !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_full: got %b want 0", bus.grid_full);
        end
    endtask

    task automatic test_bounds();
        logic [11:0] xs [6] = '{12'd8,  12'd679, 12'd680, 12'd1015, 12'd343, 12'd344};
        logic [11:0] ys [6] = '{12'd10, 12'd507, 12'd508, 12'd10,   12'd756, 12'd259};
        int          ep [6] = '{1, 1, 1, 1, 1, 0};
        logic [3:0]  ei [6] = '{4'd1, 4'd5, 4'd9, 4'd3, 4'd7, 4'd0};
        int p; logic [3:0] ix;
        for (int i = 0; i < 6; i++) begin
            click(xs[i], ys[i], 8, p, ix);
            vectors++;
            if (p !== ep[i] || ix !== ei[i]) begin
                miscompares++;
                $display("FAIL bound_%0d: (%0d,%0d) got pulses=%0d idx=%0d want %0d %0d",
                         i, xs[i], ys[i], p, ix, ep[i], ei[i]);
            end
        end
        vectors++;
        if (bus.square !== 9'h155 || bus.owner !== 9'h014 || bus.turn !== 1'b1) begin
            miscompares++;
            $display("FAIL bound_board: got sq=%h own=%h turn=%b want 155 014 1",
                     bus.square, bus.owner, bus.turn);
        end
        clear_board();
    endtask

    task automatic test_commit_abort();
        bus.xpos = 12'd500;
        bus.ypos = 12'd300;
        bus.mouse_left = 1'b1;
        repeat (4) tick();
        bus.start_en = 1'b0;
        tick();
        vectors++;
        if (bus.sel_valid !== 1'b0 || bus.square !== 9'h000 || bus.turn !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_on_commit: got v=%b sq=%h turn=%b want 0 000 0",
                     bus.sel_valid, bus.square, bus.turn);
        end
        bus.start_en = 1'b1;
        bus.mouse_left = 1'b0;
        repeat (8) tick();
        vectors++;
        if (bus.square !== 9'h000) begin
            miscompares++;
            $display("FAIL abort_after: got sq=%h want 000", bus.square);
        end
    endtask

    task automatic test_fill();
        logic [11:0] cx [3] = '{12'd175, 12'd511, 12'd847};
        logic [11:0] cy [3] = '{12'd134, 12'd383, 12'd632};
        int p; logic [3:0] ix;
        logic [3:0] want;
        for (int k = 0; k < 9; k++) begin
            click(cx[k % 3], cy[k / 3], 8, p, ix);
            want = 4'(k + 1);
            vectors++;
            if (p !== 1 || ix !== want) begin
                miscompares++;
                $display("FAIL fill_%0d: got pulses=%0d idx=%0d want 1 %0d", k, p, ix, want);
            end
        end
        vectors++;
        if (bus.grid_full !== 1'b1 || bus.square !== 9'h1ff || bus.owner !== 9'b010101010 || bus.turn !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_board: got full=%b sq=%h own=%b turn=%b want 1 1ff 010101010 1",
                     bus.grid_full, bus.square, bus.owner, bus.turn);
        end
        click(cx[1], cy[1], 8, p, ix);
        vectors++;
        if (p !== 0 || bus.square !== 9'h1ff || bus.turn !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_tenth: got pulses=%0d sq=%h turn=%b want 0 1ff 1", p, bus.square, bus.turn);
        end
        test_clear();
    endtask

    task automatic test_rst_mid();
        int p = 0; logic [3:0] ix;
        click(12'd175, 12'd134, 8, p, ix);
        vectors++;
        if (p !== 1 || bus.square !== 9'h001) begin
            miscompares++;
            $display("FAIL rst_mid_setup: got pulses=%0d sq=%h want 1 001", p, bus.square);
        end
        bus.xpos = 12'd500;
        bus.ypos = 12'd300;
        bus.mouse_left = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        vectors++;
        if (bus.square !== 9'h000 || bus.owner !== 9'h000 || bus.turn !== 1'b0 ||
            bus.sel_valid !== 1'b0 || bus.sel_idx !== 4'd0 || bus.grid_full !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got sq=%h own=%h turn=%b v=%b idx=%0d full=%b want all zero",
                     bus.square, bus.owner, bus.turn, bus.sel_valid, bus.sel_idx, bus.grid_full);
        end
        p = 0;
        repeat (20) begin
            tick();
            if (bus.sel_valid) p++;
        end
        vectors++;
        if (p !== 0 || bus.square !== 9'h000) begin
            miscompares++;
            $display("FAIL rst_held_button: got pulses=%0d sq=%h want 0 000", p, bus.square);
        end
        bus.mouse_left = 1'b0;
        repeat (6) tick();
        click(12'd500, 12'd300, 8, p, ix);
        vectors++;
        if (p !== 1 || ix !== 4'd5 || bus.square !== 9'h010) begin
            miscompares++;
            $display("FAIL rst_repress: got pulses=%0d idx=%0d sq=%h want 1 5 010", p, ix, bus.square);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_center_latency();
        test_repeat_click();
        test_outside();
        test_hold();
        test_clear();
        test_bounds();
        test_commit_abort();
        test_fill();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
